// File: rtl/vga_timing_pkg.sv
// ----------------------------------------------------------------------------
// vga_timing_pkg
// Shared definitions for the VGA timing generators.
//   - ST_* : state encodings used by the vertical generator and exposed on its
//            debug state output.
//   - DEF_*_LINES : default 640x480 vertical interval lengths.
//   - min_cnt_width() : smallest counter width that can hold a given value.
// ----------------------------------------------------------------------------
package vga_timing_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SYNC   = 3'd1;
    localparam logic [2:0] ST_BACK   = 3'd2;
    localparam logic [2:0] ST_ACTIVE = 3'd3;
    localparam logic [2:0] ST_FRONT  = 3'd4;

    localparam int DEF_PULSE_LINES  = 2;
    localparam int DEF_BACK_LINES   = 29;
    localparam int DEF_ACTIVE_LINES = 480;
    localparam int DEF_FRONT_LINES  = 10;

    // Number of bits needed to represent max_value (at least 1).
    function automatic int min_cnt_width(input int max_value);
        int w;
        w = 1;
        while ((1 << w) <= max_value) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/vga_interval_counter.sv
// ----------------------------------------------------------------------------
// vga_interval_counter
// Tick-enabled counter with terminal-count compare and synchronous clear.
// Counts 0..i_last, advancing only on i_tick, and wraps to 0 on the tick that
// arrives while at i_last.
// Ports:
//   clk, reset     : clock, asynchronous active-high reset
//   i_clear        : synchronous clear (wins over i_tick)
//   i_tick         : advance strobe
//   i_last         : terminal value of the current interval
//   o_count_nxt    : value the counter takes at the next clk edge, so the
//                    parent can register outputs aligned with the counter
//   o_at_last      : current count equals i_last
// ----------------------------------------------------------------------------
module vga_interval_counter #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_clear,
    input  logic         i_tick,
    input  logic [W-1:0] i_last,
    output logic [W-1:0] o_count_nxt,
    output logic         o_at_last
);

    logic [W-1:0] r_count;

    assign o_at_last = (r_count == i_last);

    always_comb begin
        o_count_nxt = r_count;
        if (i_clear) begin
            o_count_nxt = '0;
        end else if (i_tick) begin
            o_count_nxt = o_at_last ? '0 : r_count + W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else begin
            r_count <= o_count_nxt;
        end
    end

endmodule

// File: rtl/vga_vtiming_gen.sv
// ----------------------------------------------------------------------------
// vga_vtiming_gen
// Vertical timing generator. Steps SYNC -> BACK -> ACTIVE -> FRONT -> SYNC,
// advancing whole lines on line_tick from the horizontal generator.
// Ports:
//   clk, reset      : clock, asynchronous active-high reset
//   enable          : run request; low returns to IDLE on the next clk
//   line_tick       : one-cycle end-of-line strobe
//   vsync           : vertical sync, active level set by SYNC_ACTIVE_LOW
//   display_active  : high only in ACTIVE
//   line            : active line index, 0 outside ACTIVE
//   row             : line / SCALE, 0 outside ACTIVE
//   frame_start     : one-cycle pulse on every entry to SYNC
//   frame_count     : completed frames, wrapping
//   state           : current state encoding (debug)
// All outputs are registered and updated on the same edge as the state, by
// computing each from the next-state values.
// ----------------------------------------------------------------------------
module vga_vtiming_gen
    import vga_timing_pkg::*;
#(
    parameter int PULSE_LINES     = DEF_PULSE_LINES,
    parameter int BACK_LINES      = DEF_BACK_LINES,
    parameter int ACTIVE_LINES    = DEF_ACTIVE_LINES,
    parameter int FRONT_LINES     = DEF_FRONT_LINES,
    parameter int SCALE           = 4,
    parameter bit SYNC_ACTIVE_LOW = 1'b1,
    parameter int LINE_W          = 10,
    parameter int ROW_W           = 7,
    parameter int FRAME_W         = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               line_tick,
    output logic               vsync,
    output logic               display_active,
    output logic [LINE_W-1:0]  line,
    output logic [ROW_W-1:0]   row,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame_count,
    output logic [2:0]         state
);

    localparam int   SUB_W    = min_cnt_width(SCALE - 1);
    localparam logic SYNC_LVL = SYNC_ACTIVE_LOW ? 1'b0 : 1'b1;

    logic [2:0]         r_state;
    logic               r_vsync;
    logic               r_active;
    logic [LINE_W-1:0]  r_line;
    logic [ROW_W-1:0]   r_row;
    logic [SUB_W-1:0]   r_sub;
    logic               r_frame_start;
    logic [FRAME_W-1:0] r_frame_count;

    logic               w_running;
    logic [LINE_W-1:0]  w_last;
    logic [LINE_W-1:0]  w_cnt_nxt;
    logic               w_at_last;
    logic               w_end;
    logic [2:0]         w_state_nxt;
    logic               w_frame_start_nxt;
    logic [FRAME_W-1:0] w_frame_count_nxt;
    logic [ROW_W-1:0]   w_row_nxt;
    logic [SUB_W-1:0]   w_sub_nxt;

    // Counting happens only in the four frame intervals with enable high;
    // everywhere else the interval counter is held at 0.
    assign w_running = enable && (r_state == ST_SYNC || r_state == ST_BACK ||
                                  r_state == ST_ACTIVE || r_state == ST_FRONT);

    always_comb begin
        w_last = '0;
        case (r_state)
            ST_SYNC:   w_last = LINE_W'(PULSE_LINES - 1);
            ST_BACK:   w_last = LINE_W'(BACK_LINES - 1);
            ST_ACTIVE: w_last = LINE_W'(ACTIVE_LINES - 1);
            ST_FRONT:  w_last = LINE_W'(FRONT_LINES - 1);
            default:   w_last = '0;
        endcase
    end

    vga_interval_counter #(.W(LINE_W)) u_line_cnt (
        .clk         (clk),
        .reset       (reset),
        .i_clear     (!w_running),
        .i_tick      (line_tick),
        .i_last      (w_last),
        .o_count_nxt (w_cnt_nxt),
        .o_at_last   (w_at_last)
    );

    assign w_end = line_tick && w_at_last;

    always_comb begin
        w_state_nxt       = r_state;
        w_frame_start_nxt = 1'b0;
        w_frame_count_nxt = r_frame_count;
        if (!enable) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt       = ST_SYNC;
                    w_frame_start_nxt = 1'b1;
                end
                ST_SYNC:   if (w_end) w_state_nxt = ST_BACK;
                ST_BACK:   if (w_end) w_state_nxt = ST_ACTIVE;
                ST_ACTIVE: if (w_end) w_state_nxt = ST_FRONT;
                ST_FRONT: begin
                    if (w_end) begin
                        w_state_nxt       = ST_SYNC;
                        w_frame_start_nxt = 1'b1;
                        w_frame_count_nxt = r_frame_count + FRAME_W'(1);
                    end
                end
                default:   w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Row divider: sub-counter counts lines within a logical row. Entering
    // ACTIVE finds both already cleared, so row 0 starts at line 0.
    always_comb begin
        w_sub_nxt = r_sub;
        w_row_nxt = r_row;
        if (w_state_nxt != ST_ACTIVE) begin
            w_sub_nxt = '0;
            w_row_nxt = '0;
        end else if (r_state == ST_ACTIVE && line_tick) begin
            if (r_sub == SUB_W'(SCALE - 1)) begin
                w_sub_nxt = '0;
                w_row_nxt = r_row + ROW_W'(1);
            end else begin
                w_sub_nxt = r_sub + SUB_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_vsync       <= ~SYNC_LVL;
            r_active      <= 1'b0;
            r_line        <= '0;
            r_row         <= '0;
            r_sub         <= '0;
            r_frame_start <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_vsync       <= (w_state_nxt == ST_SYNC) ? SYNC_LVL : ~SYNC_LVL;
            r_active      <= (w_state_nxt == ST_ACTIVE);
            r_line        <= (w_state_nxt == ST_ACTIVE) ? w_cnt_nxt : '0;
            r_row         <= w_row_nxt;
            r_sub         <= w_sub_nxt;
            r_frame_start <= w_frame_start_nxt;
            r_frame_count <= w_frame_count_nxt;
        end
    end

    assign vsync          = r_vsync;
    assign display_active = r_active;
    assign line           = r_line;
    assign row            = r_row;
    assign frame_start    = r_frame_start;
    assign frame_count    = r_frame_count;
    assign state          = r_state;

endmodule

// File: tb/tb_vga_vtiming_gen.sv
// ----------------------------------------------------------------------------
// tb_vga_vtiming_gen
// Two instances on a small 2/3/8/1 frame (14 lines):
//   u_dut_a : active-low vsync, SCALE=2, FRAME_W=2, line_tick every 4 clocks
//   u_dut_b : active-high vsync, SCALE=1, line_tick every clock
// Expected per-position values come from hand-written tables for one frame.
// ----------------------------------------------------------------------------
module tb_vga_vtiming_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic en_a, tick_a, en_b, tick_b;

    logic       a_vsync, a_act, a_fs;
    logic [3:0] a_line;
    logic [2:0] a_row;
    logic [1:0] a_fc;
    logic [2:0] a_st;

    logic       b_vsync, b_act, b_fs;
    logic [3:0] b_line;
    logic [3:0] b_row;
    logic [7:0] b_fc;
    logic [2:0] b_st;

    vga_vtiming_gen #(
        .PULSE_LINES(2), .BACK_LINES(3), .ACTIVE_LINES(8), .FRONT_LINES(1),
        .SCALE(2), .SYNC_ACTIVE_LOW(1'b1), .LINE_W(4), .ROW_W(3), .FRAME_W(2)
    ) u_dut_a (
        .clk(clk), .reset(reset), .enable(en_a), .line_tick(tick_a),
        .vsync(a_vsync), .display_active(a_act), .line(a_line), .row(a_row),
        .frame_start(a_fs), .frame_count(a_fc), .state(a_st)
    );

    vga_vtiming_gen #(
        .PULSE_LINES(2), .BACK_LINES(3), .ACTIVE_LINES(8), .FRONT_LINES(1),
        .SCALE(1), .SYNC_ACTIVE_LOW(1'b0), .LINE_W(4), .ROW_W(4), .FRAME_W(8)
    ) u_dut_b (
        .clk(clk), .reset(reset), .enable(en_b), .line_tick(tick_b),
        .vsync(b_vsync), .display_active(b_act), .line(b_line), .row(b_row),
        .frame_start(b_fs), .frame_count(b_fc), .state(b_st)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Position p = lines elapsed since entering SYNC.
    int exp_state [14] = '{1, 1, 2, 2, 2, 3, 3, 3, 3, 3, 3, 3, 3, 4};
    int exp_line  [14] = '{0, 0, 0, 0, 0, 0, 1, 2, 3, 4, 5, 6, 7, 0};
    int exp_row_a [14] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 2, 2, 3, 3, 0};

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_tick_a();
        tick_a = 1'b1;
        step();
        tick_a = 1'b0;
    endtask

    task automatic check_a_pos(input int p, input int fc, input string ctx);
        check_val($sformatf("%s state p%0d", ctx, p), 32'(a_st), 32'(exp_state[p]));
        check_val($sformatf("%s vsync p%0d", ctx, p), 32'(a_vsync),
                  (exp_state[p] == 1) ? 32'd0 : 32'd1);
        check_val($sformatf("%s active p%0d", ctx, p), 32'(a_act),
                  (exp_state[p] == 3) ? 32'd1 : 32'd0);
        check_val($sformatf("%s line p%0d", ctx, p), 32'(a_line), 32'(exp_line[p]));
        check_val($sformatf("%s row p%0d", ctx, p), 32'(a_row), 32'(exp_row_a[p]));
        check_val($sformatf("%s fstart p%0d", ctx, p), 32'(a_fs),
                  (p == 0) ? 32'd1 : 32'd0);
        check_val($sformatf("%s fcount p%0d", ctx, p), 32'(a_fc), 32'(fc));
    endtask

    initial begin
        reset = 1'b1;
        en_a = 1'b0; tick_a = 1'b0;
        en_b = 1'b0; tick_b = 1'b0;
        #12;

        // Reset values on both instances.
        check_val("rst a state",  32'(a_st),    32'd0);
        check_val("rst a vsync",  32'(a_vsync), 32'd1);
        check_val("rst a active", 32'(a_act),   32'd0);
        check_val("rst a line",   32'(a_line),  32'd0);
        check_val("rst a row",    32'(a_row),   32'd0);
        check_val("rst a fstart", 32'(a_fs),    32'd0);
        check_val("rst a fcount", 32'(a_fc),    32'd0);
        check_val("rst b vsync",  32'(b_vsync), 32'd0);
        check_val("rst b state",  32'(b_st),    32'd0);

        step();
        reset = 1'b0;
        step();
        check_val("idle hold a state", 32'(a_st), 32'd0);

        // Frames 1..5: entry pulse, then 70 line ticks every 4 clocks.
        en_a = 1'b1;
        step();
        check_a_pos(0, 0, "entry");
        step();
        check_val("entry fstart drop", 32'(a_fs), 32'd0);
        check_val("entry state hold",  32'(a_st), 32'd1);
        for (int t = 1; t <= 70; t++) begin
            pulse_tick_a();
            check_a_pos(t % 14, (t / 14) % 4, "run");
            step();
            check_val($sformatf("run fstart gap t%0d", t), 32'(a_fs), 32'd0);
            step();
            step();
        end

        // Drop enable at line 5 together with a tick.
        for (int t = 1; t <= 10; t++) begin
            pulse_tick_a();
            check_a_pos(t, 1, "pre-drop");
            step(); step(); step();
        end
        en_a   = 1'b0;
        tick_a = 1'b1;
        step();
        tick_a = 1'b0;
        check_val("drop state",  32'(a_st),    32'd0);
        check_val("drop active", 32'(a_act),   32'd0);
        check_val("drop line",   32'(a_line),  32'd0);
        check_val("drop row",    32'(a_row),   32'd0);
        check_val("drop vsync",  32'(a_vsync), 32'd1);
        check_val("drop fstart", 32'(a_fs),    32'd0);
        check_val("drop fcount", 32'(a_fc),    32'd1);
        step();
        check_val("drop idle hold", 32'(a_st), 32'd0);
        en_a = 1'b1;
        step();
        check_a_pos(0, 1, "reenable");

        // Reset asserted mid-BACK, between clock edges.
        for (int t = 1; t <= 3; t++) begin
            step(); step(); step();
            pulse_tick_a();
            check_a_pos(t, 1, "pre-reset");
        end
        #3;
        reset = 1'b1;
        #1;
        check_val("midrst state",  32'(a_st),    32'd0);
        check_val("midrst vsync",  32'(a_vsync), 32'd1);
        check_val("midrst active", 32'(a_act),   32'd0);
        check_val("midrst line",   32'(a_line),  32'd0);
        check_val("midrst fcount", 32'(a_fc),    32'd0);
        check_val("midrst fstart", 32'(a_fs),    32'd0);
        #2;
        reset = 1'b0;
        step();
        check_a_pos(0, 0, "post-reset");
        en_a = 1'b0;

        // Active-high vsync, SCALE=1, tick on every clock.
        en_b   = 1'b1;
        tick_b = 1'b1;
        for (int c = 0; c < 28; c++) begin
            step();
            check_val($sformatf("b state c%0d", c), 32'(b_st), 32'(exp_state[c % 14]));
            check_val($sformatf("b vsync c%0d", c), 32'(b_vsync),
                      (exp_state[c % 14] == 1) ? 32'd1 : 32'd0);
            check_val($sformatf("b line c%0d", c), 32'(b_line), 32'(exp_line[c % 14]));
            check_val($sformatf("b row c%0d", c), 32'(b_row), 32'(exp_line[c % 14]));
            check_val($sformatf("b fstart c%0d", c), 32'(b_fs),
                      ((c % 14) == 0) ? 32'd1 : 32'd0);
            check_val($sformatf("b fcount c%0d", c), 32'(b_fc), 32'(c / 14));
        end
        tick_b = 1'b0;
        en_b   = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
